// File: rtl/fetch_pkg.sv
`default_nettype none
//==============================================================================
// Module   : fetch_pkg
// Brief    : Shared NPC select codes, fetch state encoding and default widths.
// Revision : 1.0
//==============================================================================
package fetch_pkg;

   localparam int FETCH_ADDR_W = 32;
   localparam int FETCH_INST_W = 32;
   localparam int FETCH_PERF_W = 32;

   localparam logic [1:0] NPC_PC4  = 2'b00;
   localparam logic [1:0] NPC_BR   = 2'b01;
   localparam logic [1:0] NPC_JALR = 2'b10;
   localparam logic [1:0] NPC_JAL  = 2'b11;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_FULL  = 2'd2,
      ST_DRAIN = 2'd3
   } fetch_state_e;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
//==============================================================================
// Module   : fetch_ctrl_if
// Brief    : PC / NPC, instruction-memory, ID-stage and perf signals of fetch_ctrl.
// Revision : 1.0
//==============================================================================
interface fetch_ctrl_if
   import fetch_pkg::*;
#(
   parameter int ADDR_W = FETCH_ADDR_W,
   parameter int INST_W = FETCH_INST_W,
   parameter int PERF_W = FETCH_PERF_W
);
   logic [ADDR_W-1:0] pc;
   logic              pc_we;
   logic [1:0]        npc_op;
   logic              redirect_valid;
   logic [1:0]        redirect_op;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_rdy;
   logic [INST_W-1:0] imem_rdata;
   logic              inst_valid;
   logic [INST_W-1:0] inst;
   logic [ADDR_W-1:0] inst_pc;
   logic              id_ready;
   logic              flush;
   logic [PERF_W-1:0] perf_fetch_cnt;
   logic [PERF_W-1:0] perf_stall_cnt;

   modport master (
      input  pc, redirect_valid, redirect_op, imem_rdy, imem_rdata, id_ready,
      output pc_we, npc_op, imem_req, imem_addr, inst_valid, inst, inst_pc,
             flush, perf_fetch_cnt, perf_stall_cnt
   );

   modport slave (
      output pc, redirect_valid, redirect_op, imem_rdy, imem_rdata, id_ready,
      input  pc_we, npc_op, imem_req, imem_addr, inst_valid, inst, inst_pc,
             flush, perf_fetch_cnt, perf_stall_cnt
   );
endinterface : fetch_ctrl_if
`default_nettype wire

// File: rtl/fetch_perf_cnt.sv
`default_nettype none
//==============================================================================
// Module   : fetch_perf_cnt
// Brief    : Delivered-instruction and ID-stall counters, wrapping at 2^PERF_W.
// Revision : 1.0
//==============================================================================
module fetch_perf_cnt
   import fetch_pkg::*;
#(
   parameter int PERF_W = FETCH_PERF_W
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic              i_inst_valid,
   input  wire logic              i_id_ready,
   input  wire logic              i_redirect_valid,
   output logic      [PERF_W-1:0] o_fetch_cnt,
   output logic      [PERF_W-1:0] o_stall_cnt
);
   logic [PERF_W-1:0] r_fetch_cnt;
   logic [PERF_W-1:0] r_stall_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fetch_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (i_inst_valid && i_id_ready && !i_redirect_valid)
            r_fetch_cnt <= r_fetch_cnt + 1'b1;
         if (i_inst_valid && !i_id_ready)
            r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign o_fetch_cnt = r_fetch_cnt;
   assign o_stall_cnt = r_stall_cnt;
endmodule : fetch_perf_cnt
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : fetch_ctrl
// Brief    : IF-stage sequencer: PC advance, imem req/rdy, one-entry ID buffer,
//            EX redirects. Optional counters enabled by macro FETCH_PERF_EN.
// Revision : 1.0
//==============================================================================
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int ADDR_W = FETCH_ADDR_W,
   parameter int INST_W = FETCH_INST_W,
   parameter int PERF_W = FETCH_PERF_W
) (
   input  wire logic  clk,
   input  wire logic  rst,
   fetch_ctrl_if.master bus
);
   fetch_state_e      r_state;
   fetch_state_e      w_state_nxt;
   logic              r_out;
   logic [ADDR_W-1:0] r_addr;
   logic [INST_W-1:0] r_inst;
   logic [ADDR_W-1:0] r_inst_pc;

   logic              w_redirect;
   logic              w_req;
   logic              w_capture;
   logic              w_inst_valid;
   logic [ADDR_W-1:0] w_addr;

   always_comb begin
      w_state_nxt = r_state;
      w_redirect  = 1'b0;
      w_req       = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         ST_BOOT: begin
            w_state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            w_redirect = bus.redirect_valid;
            w_req      = 1'b1;
            if (w_redirect)
               w_state_nxt = bus.imem_rdy ? ST_FETCH : ST_DRAIN;
            else if (bus.imem_rdy) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_FULL;
            end
         end
         ST_FULL: begin
            // A redirect wins over a pending hand-off, so no request starts then.
            w_redirect = bus.redirect_valid;
            if (w_redirect)
               w_state_nxt = ST_FETCH;
            else if (bus.id_ready) begin
               w_req = 1'b1;
               if (bus.imem_rdy)
                  w_capture = 1'b1;
               else
                  w_state_nxt = ST_FETCH;
            end
         end
         ST_DRAIN: begin
            w_redirect = bus.redirect_valid;
            w_req      = 1'b1;
            if (bus.imem_rdy)
               w_state_nxt = ST_FETCH;
         end
         default: begin
            w_state_nxt = ST_BOOT;
         end
      endcase
   end

   // A request's first cycle presents the live PC; later cycles replay the latch.
   assign w_addr       = (w_req && !r_out) ? bus.pc : r_addr;
   assign w_inst_valid = (r_state == ST_FULL);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_BOOT;
         r_out     <= 1'b0;
         r_addr    <= '0;
         r_inst    <= '0;
         r_inst_pc <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_out   <= w_req && !bus.imem_rdy;
         if (w_req)
            r_addr <= w_addr;
         if (w_capture) begin
            r_inst    <= bus.imem_rdata;
            r_inst_pc <= w_addr;
         end
      end
   end

   assign bus.pc_we      = w_redirect || w_capture;
   assign bus.npc_op     = w_redirect ? bus.redirect_op : NPC_PC4;
   assign bus.flush      = w_redirect;
   assign bus.imem_req   = w_req;
   assign bus.imem_addr  = w_addr;
   assign bus.inst_valid = w_inst_valid;
   assign bus.inst       = r_inst;
   assign bus.inst_pc    = r_inst_pc;

`ifdef FETCH_PERF_EN
   fetch_perf_cnt #(
      .PERF_W (PERF_W)
   ) u_perf (
      .clk              (clk),
      .rst              (rst),
      .i_inst_valid     (w_inst_valid),
      .i_id_ready       (bus.id_ready),
      .i_redirect_valid (bus.redirect_valid),
      .o_fetch_cnt      (bus.perf_fetch_cnt),
      .o_stall_cnt      (bus.perf_stall_cnt)
   );
`else
   assign bus.perf_fetch_cnt = {PERF_W{1'b0}};
   assign bus.perf_stall_cnt = {PERF_W{1'b0}};
`endif

endmodule : fetch_ctrl
`default_nettype wire

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the instruction-fetch stage. Decides when the PC register advances and which npc_op the NPC unit applies.
- Issues req/rdy transactions to a variable-latency instruction memory and holds the fetched instruction in a one-entry buffer toward ID.
- Applies EX-stage redirects (branch/jump), discards stale in-flight fetches, and raises flush to ID.

Parameters:
ADDR_W, 32, PC / memory address width
INST_W, 32, instruction width
PERF_W, 32, perf counter width (used only with FETCH_PERF_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
pc  in  ADDR_W  current PC from PC register
pc_we  out  1  PC register load enable (PC <= npc next edge)
npc_op  out  2  NPC select: 00 pc+4, 01 pc+imm (branch), 10 rD1+imm (jalr), 11 pc+imm (jal)
redirect_valid  in  1  EX-stage taken branch/jump, single-cycle pulse
redirect_op  in  2  npc_op to apply on redirect (01/10/11)
imem_req  out  1  fetch request
imem_addr  out  ADDR_W  fetch address, stable while imem_req high
imem_rdy  in  1  memory response; data valid this cycle
imem_rdata  in  INST_W  instruction data
inst_valid  out  1  buffer holds a valid instruction for ID
inst  out  INST_W  buffered instruction
inst_pc  out  ADDR_W  PC of buffered instruction
id_ready  in  1  ID accepts inst this cycle (low = stall)
flush  out  1  kill ID-stage instruction, one-cycle pulse
perf_fetch_cnt  out  PERF_W  instructions delivered (FETCH_PERF_EN)
perf_stall_cnt  out  PERF_W  cycles inst_valid&&!id_ready (FETCH_PERF_EN)

Behaviour:
- Reset (rst=0, async): state=BOOT; pc_we=0, npc_op=00, imem_req=0, imem_addr=0, inst_valid=0, inst=0, inst_pc=0, flush=0, perf counters=0.
- States: BOOT, FETCH, FULL, DRAIN.
- BOOT: outputs idle for one cycle after reset release, then go to FETCH. The PC already holds its reset value.
- Request rule: when a new request starts, imem_addr latches pc and req goes high. Req and addr stay stable until imem_rdy is sampled high. imem_rdy is ignored while req is low.
- FETCH: req high. On rdy without redirect: capture rdata to inst and imem_addr to inst_pc; pc_we=1 with npc_op=00; go to FULL. Zero-wait memory (rdy in the first req cycle) is legal.
- FULL: inst_valid=1. If id_ready=0: hold; req low; pc_we=0.
- FULL with id_ready=1: buffer consumed. A new request starts in the same cycle (req combinationally high).
  - rdy same cycle: recapture, stay FULL. Throughput is 1 instr/cycle.
  - No rdy: go to FETCH with request outstanding.
- Redirect (highest priority, any state except BOOT, which ignores it): pc_we=1, npc_op=redirect_op, flush=1; inst_valid cleared next cycle.
  - No outstanding request, or rdy in same cycle (data dropped): go to FETCH with a fresh request next cycle.
  - Outstanding request without rdy: go to DRAIN.
- DRAIN: req/addr held on the stale request. On rdy, data is dropped and state goes to FETCH. A further redirect in DRAIN updates the PC again and stays in DRAIN.
- Redirect overrides id_ready=0. pc_we never asserts without a capture or a redirect.
- Latency: rdy at cycle N gives inst_valid at N+1, with pc advanced at N+1.

Optional Feature:
- FETCH_PERF_EN defined: perf_fetch_cnt increments on every inst_valid&&id_ready&&!redirect_valid. perf_stall_cnt increments on every inst_valid&&!id_ready. Both wrap modulo 2^PERF_W.
- Undefined: no counter logic; both ports tied to 0.

Decomposition:
- Shared package fetch_pkg holds:
  - NPC_PC4=2'b00, NPC_BR=2'b01, NPC_JALR=2'b10, NPC_JAL=2'b11.
  - fetch state encoding: BOOT=0, FETCH=1, FULL=2, DRAIN=3.
  - widths.
- One sub-module, fetch_perf_cnt: the two counters, instantiated only under FETCH_PERF_EN.

Test Plan:
- Reset then zero-wait memory (rdy tied 1), id_ready=1, pc 0x0 -> inst_valid from cycle 3, inst_pc 0x0,0x4,0x8 consecutive, pc_we high every cycle.
- 3-cycle memory latency -> imem_addr stable 3 cycles, one instruction per 3 cycles, npc_op=00 on each capture.
- FULL with id_ready=0 for 5 cycles -> inst/inst_pc constant, imem_req=0, pc_we=0. Under FETCH_PERF_EN, perf_stall_cnt += 5.
- Redirect_op=01 during outstanding 4-cycle request at 0x10 -> flush pulse, pc_we with npc_op=01, DRAIN. The 0x10 data is dropped and the next request uses the branch target.
- Redirect coincident with rdy while FULL and id_ready=0 -> data dropped, inst_valid=0 next cycle, fresh request next cycle.
- Assert rst=0 mid-request in DRAIN -> all outputs 0 immediately (async), BOOT after release.
